prod_bcd_conv: RTL

PROD_BCD_CONV -- requirements
Module: prod_bcd_conv

---
 rtl/prod_bcd_conv_pkg.sv | 15 +
 rtl/prod_bcd_conv_digit_adj.sv | 16 +
 rtl/prod_bcd_conv.sv | 115 +++++++++++
 3 files changed

// File: rtl/prod_bcd_conv_pkg.sv
// Shared types and constants for the product-to-BCD converter.
// The converter uses a double-dabble (shift-and-add-3) algorithm.
package prod_bcd_conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A digit at or above this value would exceed 9 after doubling, so it is pre-corrected
   localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
   localparam logic [3:0] ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/prod_bcd_conv_digit_adj.sv
// Combinational per-digit correction for double-dabble: add 3 when the digit is 5 or more.
module bcd_digit_adj
   import prod_bcd_conv_pkg::*;
(
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= ADD3_THRESHOLD) begin
         digit_out = digit_in + ADD3_VALUE;
      end
   end

endmodule

// File: rtl/prod_bcd_conv.sv
// Converts the binary product from the sequential multiplier into packed BCD,
// one bit per clock, triggered by the rising edge of the multiplier's done strobe.
module prod_bcd_conv
   import prod_bcd_conv_pkg::*;
#(
   parameter int N_BITS   = 16,
   parameter int N_DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    done_flag,
   input  logic [N_BITS-1:0]       product8x8_out,
   output logic                    busy,
   output logic                    bcd_valid,
   output logic [4*N_DIGITS-1:0]   bcd_out,
   output logic                    overrun
);

   localparam int CNT_W = $clog2(N_BITS + 1);
   localparam int BCD_W = 4 * N_DIGITS;

   state_t              state;
   state_t              state_nxt;
   logic                done_d;
   logic                req;
   logic                last_shift;
   logic                illegal;
   logic [N_BITS-1:0]   bin_sr;
   logic [BCD_W-1:0]    acc;
   logic [BCD_W-1:0]    acc_adj;
   logic [BCD_W-1:0]    acc_shifted;
   logic [CNT_W-1:0]    cnt;

   assign req        = done_flag & ~done_d;
   assign last_shift = (cnt == CNT_W'(N_BITS - 1));
   assign illegal    = (state != IDLE) && (state != SHIFT) && (state != DONE);

   for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (acc[4*d +: 4]),
         .digit_out (acc_adj[4*d +: 4])
      );
   end

   // Corrected accumulator shifted left, binary MSB entering the bottom bit
   assign acc_shifted = {acc_adj[BCD_W-2:0], bin_sr[N_BITS-1]};

   assign busy      = (state == SHIFT) || (state == DONE);
   assign bcd_valid = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = SHIFT;
         SHIFT:   if (last_shift) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         done_d <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_d <= done_flag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_sr  <= '0;
         acc     <= '0;
         cnt     <= '0;
         bcd_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  bin_sr <= product8x8_out;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               acc    <= acc_shifted;
               bin_sr <= {bin_sr[N_BITS-2:0], 1'b0};
               cnt    <= cnt + CNT_W'(1);
               if (last_shift) begin
                  bcd_out <= acc_shifted;
               end
            end
            DONE: begin
            end
            default: begin
               bin_sr  <= '0;
               acc     <= '0;
               cnt     <= '0;
               bcd_out <= '0;
            end
         endcase
      end
   end

   // A request seen outside IDLE (including the DONE cycle) is dropped and flagged
   always_ff @(posedge clk) begin
      if (reset || illegal) begin
         overrun <= 1'b0;
      end else if (req && (state != IDLE)) begin
         overrun <= 1'b1;
      end
   end

endmodule
